// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq -- parametrised reset sequencer for the PicoSoC top level.
//
// Takes the board's asynchronous active-low reset and releases NUM_OUT
// active-low reset domains one after another: bit 0 (CPU/SoC) first, then
// the peripheral domains, STAGE_GAP cycles apart. The sequence is
// re-entered on a software request and, when RESET_SEQ_LOCK_EN is defined,
// on PLL lock loss. The cause of the last reset is held for firmware.
//
// Optional feature macro: RESET_SEQ_LOCK_EN
//   defined   : pll_locked is synchronised, the FSM waits for lock before
//               HOLD, and lock loss forces a reset with cause 01.
//   undefined : pll_locked is ignored (port kept for compatibility).
//
// Ports:
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   pll_locked  in   PLL lock, asynchronous to clk
//   sw_rst_req  in   single-cycle software reset request
//   rst_out_n   out  [NUM_OUT-1:0] active-low domain resets, bit 0 first
//   busy        out  high while any rst_out_n bit is low
//   rst_cause   out  [1:0] 00 power-on, 01 lock loss, 10 software
// ---------------------------------------------------------------------------
module reset_seq #(
    parameter int HOLD_CYCLES = 8,
    parameter int NUM_OUT     = 3,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               busy,
    output logic [1:0]         rst_cause
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [2:0] {
        ASSERT,
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               busy_q, busy_d;
    logic [1:0]         cause_q, cause_d;

    // Reset-release synchroniser: assertion is asynchronous, release takes
    // SYNC_STAGES edges.
    logic [SYNC_STAGES-1:0] rsync_q;
    logic                   rst_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rsync_q <= '0;
        else         rsync_q <= {rsync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync = rsync_q[SYNC_STAGES-1];

    logic lock_sync;
    logic lock_lost;

`ifdef RESET_SEQ_LOCK_EN
    localparam bit LOCK_EN = 1'b1;

    logic [SYNC_STAGES-1:0] lsync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lsync_q <= '0;
        else         lsync_q <= {lsync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign lock_sync = lsync_q[SYNC_STAGES-1];
`else
    localparam bit LOCK_EN = 1'b0;

    logic unused_pll_locked;
    assign unused_pll_locked = pll_locked;
    assign lock_sync         = 1'b1;
`endif

    assign lock_lost = LOCK_EN && !lock_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        cause_d = cause_q;

        if (!rst_sync) begin
            // Still inside the synchroniser window: park in ASSERT.
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                    state_d = LOCK_EN ? WAIT_LOCK : HOLD;
                end

                WAIT_LOCK: begin
                    cnt_d = '0;
                    if (lock_sync) state_d = HOLD;
                end

                HOLD: begin
                    if (lock_lost) begin
                        state_d = ASSERT;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '0;
                        cause_d = CAUSE_LOCK;
                    end else if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b1;
                        cnt_d    = '0;
                        idx_d    = IW'(1);
                        state_d  = (NUM_OUT == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                RELEASE: begin
                    if (lock_lost) begin
                        state_d = ASSERT;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '0;
                        cause_d = CAUSE_LOCK;
                    end else if (cnt_q == GAP_LAST) begin
                        rst_d[idx_q] = 1'b1;
                        cnt_d        = '0;
                        if (idx_q == IDX_LAST) state_d = RUN;
                        else                   idx_d   = idx_q + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                RUN: begin
                    // Lock loss takes priority over a coincident software request.
                    if (lock_lost || sw_rst_req) begin
                        state_d = ASSERT;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '0;
                        cause_d = lock_lost ? CAUSE_LOCK : CAUSE_SW;
                    end
                end

                default: begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                end
            endcase
        end

        busy_d = ~&rst_d;
    end

    assign rst_out_n = rst_q;
    assign busy      = busy_q;
    assign rst_cause = cause_q;

endmodule
